// File: rtl/game_pkg.sv
// Shared types and helpers for the whacking-game round controller.
package game_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PREROLL = 2'b01,
    ST_PLAY    = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd2_t;

  function automatic bcd2_t to_bcd2(input int unsigned value);
    bcd2_t result;
    result.tens = 4'(value / 10);
    result.ones = 4'(value % 10);
    return result;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Input events and display/status outputs of the round controller.
// Pause member exists only when GAME_PAUSE_EN is defined.
interface game_round_ctrl_if;
  logic       SecondTick;
  logic       Start;
  logic       HitScored;
`ifdef GAME_PAUSE_EN
  logic       Pause;
`endif
  logic [3:0] TimeOnes;
  logic [3:0] TimeTens;
  logic [3:0] ScoreOnes;
  logic [3:0] ScoreTens;
  logic [1:0] State;
  logic       Playing;
  logic       GameOver;
  logic       RoundDone;

  modport master (
`ifdef GAME_PAUSE_EN
    output Pause,
`endif
    output SecondTick, Start, HitScored,
    input  TimeOnes, TimeTens, ScoreOnes, ScoreTens, State, Playing, GameOver, RoundDone
  );

  modport slave (
`ifdef GAME_PAUSE_EN
    input  Pause,
`endif
    input  SecondTick, Start, HitScored,
    output TimeOnes, TimeTens, ScoreOnes, ScoreTens, State, Playing, GameOver, RoundDone
  );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD register: load has priority, increment saturates at 99,
// decrement floors at 00.
module bcd2_counter
  import game_pkg::*;
#(
  parameter bcd2_t RESET_VAL = '0
) (
  input  logic  ClockIn,
  input  logic  Resetn,
  input  logic  Load,
  input  bcd2_t LoadVal,
  input  logic  Inc,
  input  logic  Dec,
  output bcd2_t Value,
  output logic  IsOne
);

  bcd2_t valueNext;
  logic  isMax;
  logic  isZero;

  assign isMax  = (Value.tens == BCD_NINE) && (Value.ones == BCD_NINE);
  assign isZero = (Value.tens == 4'd0) && (Value.ones == 4'd0);
  assign IsOne  = (Value.tens == 4'd0) && (Value.ones == 4'd1);

  always_comb begin
    valueNext = Value;
    if (Load) begin
      valueNext = LoadVal;
    end else if (Inc && !isMax) begin
      if (Value.ones == BCD_NINE) begin
        valueNext.ones = 4'd0;
        valueNext.tens = Value.tens + 4'd1;
      end else begin
        valueNext.ones = Value.ones + 4'd1;
      end
    end else if (Dec && !isZero) begin
      if (Value.ones == 4'd0) begin
        valueNext.ones = BCD_NINE;
        valueNext.tens = Value.tens - 4'd1;
      end else begin
        valueNext.ones = Value.ones - 4'd1;
      end
    end
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) Value <= RESET_VAL;
    else         Value <= valueNext;
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: pre-roll countdown, play countdown and saturating BCD score.
// Optional freeze input enabled by defining GAME_PAUSE_EN.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned ROUND_SECONDS   = 60,
  parameter int unsigned PREROLL_SECONDS = 3
) (
  input logic             ClockIn,
  input logic             Resetn,
  game_round_ctrl_if.slave Bus
);

  localparam bcd2_t ROUND_BCD   = to_bcd2(ROUND_SECONDS);
  localparam bcd2_t PREROLL_BCD = '{tens: 4'd0, ones: 4'(PREROLL_SECONDS)};

  state_t state, stateNext;
  logic   startQ, startArmed, startEdge;
  logic   frozen, tick, hit;
  logic   playingReg, gameOverReg, roundDoneReg, roundDoneNext;
  logic   timeLoad, timeDec, timeIsOne;
  bcd2_t  timeLoadVal, timeVal;
  logic   scoreLoad, scoreInc, scoreIsOne;
  bcd2_t  scoreVal;

`ifdef GAME_PAUSE_EN
  assign frozen = Bus.Pause && ((state == ST_PREROLL) || (state == ST_PLAY));
`else
  assign frozen = 1'b0;
`endif

  // Arming keeps a Start level held through reset release from counting as an edge.
  assign startEdge = Bus.Start && !startQ && startArmed;
  assign tick      = Bus.SecondTick && !frozen;
  assign hit       = Bus.HitScored && !frozen;

  always_comb begin
    stateNext     = state;
    timeLoad      = 1'b0;
    timeLoadVal   = ROUND_BCD;
    timeDec       = 1'b0;
    scoreLoad     = 1'b0;
    scoreInc      = 1'b0;
    roundDoneNext = 1'b0;
    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (startEdge) begin
          stateNext   = ST_PREROLL;
          timeLoad    = 1'b1;
          timeLoadVal = PREROLL_BCD;
          scoreLoad   = 1'b1;
        end
      end
      ST_PREROLL: begin
        if (tick) begin
          if (timeIsOne) begin
            stateNext = ST_PLAY;
            timeLoad  = 1'b1;
          end else begin
            timeDec = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        scoreInc = hit;
        if (tick) begin
          timeDec = 1'b1;
          if (timeIsOne) begin
            stateNext     = ST_OVER;
            roundDoneNext = 1'b1;
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state        <= ST_IDLE;
      startQ       <= 1'b0;
      startArmed   <= 1'b0;
      playingReg   <= 1'b0;
      gameOverReg  <= 1'b0;
      roundDoneReg <= 1'b0;
    end else begin
      state        <= stateNext;
      startQ       <= Bus.Start;
      startArmed   <= startArmed || !Bus.Start;
      playingReg   <= (stateNext == ST_PLAY);
      gameOverReg  <= (stateNext == ST_OVER);
      roundDoneReg <= roundDoneNext;
    end
  end

  bcd2_counter #(.RESET_VAL(ROUND_BCD)) uTime (
    .ClockIn (ClockIn),
    .Resetn  (Resetn),
    .Load    (timeLoad),
    .LoadVal (timeLoadVal),
    .Inc     (1'b0),
    .Dec     (timeDec),
    .Value   (timeVal),
    .IsOne   (timeIsOne)
  );

  bcd2_counter #(.RESET_VAL('0)) uScore (
    .ClockIn (ClockIn),
    .Resetn  (Resetn),
    .Load    (scoreLoad),
    .LoadVal ('0),
    .Inc     (scoreInc),
    .Dec     (1'b0),
    .Value   (scoreVal),
    .IsOne   (scoreIsOne)
  );

  assign Bus.TimeOnes  = timeVal.ones;
  assign Bus.TimeTens  = timeVal.tens;
  assign Bus.ScoreOnes = scoreVal.ones;
  assign Bus.ScoreTens = scoreVal.tens;
  assign Bus.State     = state;
  assign Bus.Playing   = playingReg;
  assign Bus.GameOver  = gameOverReg;
  assign Bus.RoundDone = roundDoneReg;

  logic unusedScoreOne;
  assign unusedScoreOne = scoreIsOne;

endmodule
